// File: rtl/pipeline_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_pkg
//   Shared definitions for the writeback path. The register file, the hazard
//   unit and the writeback queue all agree on these widths and on the
//   hard-wired zero register.
//
//   REG_ADDR_W  register address width (32 architectural registers)
//   DATA_W      result / register width
//   REG_ZERO    address of the hard-wired zero register (writes are dropped)
//   wb_entry_t  one pending register write: destination plus value
// ---------------------------------------------------------------------------
package pipeline_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

endpackage

// File: rtl/wb_forward_match.sv
// ---------------------------------------------------------------------------
// wb_forward_match
//   Combinational youngest-first search of the pending writes for one decode
//   read port. Queue slots are presented already ordered by age, slot 0 being
//   the youngest. The output stage (value currently on the write port) is the
//   oldest candidate and only counts while it is actually being written.
//
//   i_query      register address being read by decode
//   i_valid      per-slot occupancy, bit 0 = youngest entry
//   i_regs       packed destination addresses, slot k at [k*ADDR_W +: ADDR_W]
//   i_data       packed values, slot k at [k*DATA_W +: DATA_W]
//   i_out_valid  output stage holds a write this cycle
//   i_out_reg    output stage destination
//   i_out_data   output stage value
//   o_hit        a pending write to i_query exists
//   o_data       youngest pending value for i_query, zero when no hit
// ---------------------------------------------------------------------------
module wb_forward_match #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic [ADDR_W-1:0]       i_query,
    input  logic [DEPTH-1:0]        i_valid,
    input  logic [DEPTH*ADDR_W-1:0] i_regs,
    input  logic [DEPTH*DATA_W-1:0] i_data,
    input  logic                    i_out_valid,
    input  logic [ADDR_W-1:0]       i_out_reg,
    input  logic [DATA_W-1:0]       i_out_data,
    output logic                    o_hit,
    output logic [DATA_W-1:0]       o_data
);
    import pipeline_pkg::*;

    localparam logic [ADDR_W-1:0] ZERO_REG = ADDR_W'(REG_ZERO);

    // Walk from oldest to youngest so that the last match to win is the
    // youngest one; the zero register never reports a hit.
    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        if (i_query != ZERO_REG) begin
            if (i_out_valid && (i_out_reg == i_query)) begin
                o_hit  = 1'b1;
                o_data = i_out_data;
            end
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (i_valid[k] && (i_regs[k*ADDR_W +: ADDR_W] == i_query)) begin
                    o_hit  = 1'b1;
                    o_data = i_data[k*DATA_W +: DATA_W];
                end
            end
        end
    end

endmodule

// File: rtl/regfile_writeback_queue.sv
// ---------------------------------------------------------------------------
// regfile_writeback_queue
//   Collects completed load and ALU results, keeps them in program order and
//   retires one per cycle onto the single register-file write port. Decode
//   can look up still-pending values through two forwarding query ports.
//
//   CLOCK        rising-edge clock
//   RESET        asynchronous active-low reset; discards every pending write
//   MemValid/MemReg/MemData/MemReady   load result handshake (older source)
//   AluValid/AluReg/AluData/AluReady   ALU result handshake (younger source)
//   QueryReg1/2  decode read addresses
//   QueryHit1/2  pending write exists for that address
//   QueryData1/2 youngest pending value, zero when no hit
//   WriteEnable/RegWrite/DataWrite     registered register-file write port
//   Empty        nothing queued and nothing being written
// ---------------------------------------------------------------------------
module regfile_writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              MemValid,
    input  logic [ADDR_W-1:0] MemReg,
    input  logic [DATA_W-1:0] MemData,
    output logic              MemReady,
    input  logic              AluValid,
    input  logic [ADDR_W-1:0] AluReg,
    input  logic [DATA_W-1:0] AluData,
    output logic              AluReady,
    input  logic [ADDR_W-1:0] QueryReg1,
    input  logic [ADDR_W-1:0] QueryReg2,
    output logic              QueryHit1,
    output logic              QueryHit2,
    output logic [DATA_W-1:0] QueryData1,
    output logic [DATA_W-1:0] QueryData2,
    output logic              WriteEnable,
    output logic [ADDR_W-1:0] RegWrite,
    output logic [DATA_W-1:0] DataWrite,
    output logic              Empty
);
    import pipeline_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [ADDR_W-1:0] ZERO_REG  = ADDR_W'(REG_ZERO);
    localparam logic [CNT_W-1:0]  MEM_LIMIT = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  ALU_LIMIT = CNT_W'(DEPTH - 2);

    // Storage; occupancy is implied by the pointers and count
    logic [ADDR_W-1:0] r_reg  [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];

    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;

    // Output stage driving the register-file write port
    logic              r_we;
    logic [ADDR_W-1:0] r_wreg;
    logic [DATA_W-1:0] r_wdata;

    logic              w_mem_push;
    logic              w_alu_push;
    logic              w_pop;
    logic [PTR_W-1:0]  w_alu_slot;

    logic [DEPTH-1:0]        w_fwd_valid;
    logic [DEPTH*ADDR_W-1:0] w_fwd_regs;
    logic [DEPTH*DATA_W-1:0] w_fwd_data;

    // Ready depends on the registered count only. A pop in the same cycle is
    // not credited, so ALU needs two free slots because Mem may take one.
    assign MemReady = (r_count <= MEM_LIMIT);
    assign AluReady = (r_count <= ALU_LIMIT);

    // Writes to the zero register complete the handshake but are dropped
    assign w_mem_push = MemValid & MemReady & (MemReg != ZERO_REG);
    assign w_alu_push = AluValid & AluReady & (AluReg != ZERO_REG);
    assign w_pop      = (r_count != '0);

    // Mem is the older instruction, so it takes the first free slot
    assign w_alu_slot = r_wr_ptr + PTR_W'(w_mem_push);

    always_ff @(posedge CLOCK) begin
        if (w_mem_push) begin
            r_reg[r_wr_ptr]  <= MemReg;
            r_data[r_wr_ptr] <= MemData;
        end
        if (w_alu_push) begin
            r_reg[w_alu_slot]  <= AluReg;
            r_data[w_alu_slot] <= AluData;
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_we     <= 1'b0;
            r_wreg   <= '0;
            r_wdata  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(w_mem_push) + PTR_W'(w_alu_push);
            r_rd_ptr <= r_rd_ptr + PTR_W'(w_pop);
            r_count  <= r_count + CNT_W'(w_mem_push) + CNT_W'(w_alu_push)
                        - CNT_W'(w_pop);
            if (w_pop) begin
                r_we    <= 1'b1;
                r_wreg  <= r_reg[r_rd_ptr];
                r_wdata <= r_data[r_rd_ptr];
            end else begin
                // Address and data hold so the write port does not toggle idle
                r_we <= 1'b0;
            end
        end
    end

    // Present slots to the matchers ordered youngest (k=0) to oldest; slot k
    // sits k+1 positions behind the write pointer and is live while k < count.
    for (genvar k = 0; k < DEPTH; k++) begin : g_order
        logic [PTR_W-1:0] w_idx;
        assign w_idx          = r_wr_ptr - PTR_W'(k + 1);
        assign w_fwd_valid[k] = (CNT_W'(k) < r_count);
        assign w_fwd_regs[k*ADDR_W +: ADDR_W] = r_reg[w_idx];
        assign w_fwd_data[k*DATA_W +: DATA_W] = r_data[w_idx];
    end

    wb_forward_match #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_match1 (
        .i_query     (QueryReg1),
        .i_valid     (w_fwd_valid),
        .i_regs      (w_fwd_regs),
        .i_data      (w_fwd_data),
        .i_out_valid (r_we),
        .i_out_reg   (r_wreg),
        .i_out_data  (r_wdata),
        .o_hit       (QueryHit1),
        .o_data      (QueryData1)
    );

    wb_forward_match #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_match2 (
        .i_query     (QueryReg2),
        .i_valid     (w_fwd_valid),
        .i_regs      (w_fwd_regs),
        .i_data      (w_fwd_data),
        .i_out_valid (r_we),
        .i_out_reg   (r_wreg),
        .i_out_data  (r_wdata),
        .o_hit       (QueryHit2),
        .o_data      (QueryData2)
    );

    assign WriteEnable = r_we;
    assign RegWrite    = r_wreg;
    assign DataWrite   = r_wdata;
    assign Empty       = (r_count == '0) & ~r_we;

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// ---------------------------------------------------------------------------
// tb_regfile_writeback_queue
//   Scoreboard bench: accepted requests push their expected write into a
//   queue; a monitor pops and compares each cycle the write port is active
//   and checks ready, Empty and forwarding against that queue.
// ---------------------------------------------------------------------------
module tb_regfile_writeback_queue;
    import pipeline_pkg::*;

    localparam int DEPTH = 4;

    logic                  CLOCK = 1'b0;
    logic                  RESET = 1'b1;
    logic                  MemValid = 1'b0;
    logic [REG_ADDR_W-1:0] MemReg = '0;
    logic [DATA_W-1:0]     MemData = '0;
    logic                  MemReady;
    logic                  AluValid = 1'b0;
    logic [REG_ADDR_W-1:0] AluReg = '0;
    logic [DATA_W-1:0]     AluData = '0;
    logic                  AluReady;
    logic [REG_ADDR_W-1:0] QueryReg1 = '0;
    logic [REG_ADDR_W-1:0] QueryReg2 = '0;
    logic                  QueryHit1, QueryHit2;
    logic [DATA_W-1:0]     QueryData1, QueryData2;
    logic                  WriteEnable;
    logic [REG_ADDR_W-1:0] RegWrite;
    logic [DATA_W-1:0]     DataWrite;
    logic                  Empty;

    regfile_writeback_queue #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (REG_ADDR_W)
    ) dut (
        .CLOCK       (CLOCK),
        .RESET       (RESET),
        .MemValid    (MemValid),
        .MemReg      (MemReg),
        .MemData     (MemData),
        .MemReady    (MemReady),
        .AluValid    (AluValid),
        .AluReg      (AluReg),
        .AluData     (AluData),
        .AluReady    (AluReady),
        .QueryReg1   (QueryReg1),
        .QueryReg2   (QueryReg2),
        .QueryHit1   (QueryHit1),
        .QueryHit2   (QueryHit2),
        .QueryData1  (QueryData1),
        .QueryData2  (QueryData2),
        .WriteEnable (WriteEnable),
        .RegWrite    (RegWrite),
        .DataWrite   (DataWrite),
        .Empty       (Empty)
    );

    always #5 CLOCK = ~CLOCK;

    wb_entry_t sb[$];
    wb_entry_t out_e;
    int        checks = 0;
    int        passes = 0;
    bit        mon_en = 1'b0;
    bit        saw_stall = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    function automatic void push_exp(input logic [REG_ADDR_W-1:0] r, input logic [DATA_W-1:0] d);
        wb_entry_t e;
        e.rd   = r;
        e.data = d;
        if (r != REG_ZERO) sb.push_back(e);
    endfunction

    // Reference forwarding: queued entries youngest first, then the write port
    function automatic void fwd(input logic [REG_ADDR_W-1:0] q, output logic h,
                                output logic [DATA_W-1:0] d);
        h = 1'b0;
        d = '0;
        if (q != REG_ZERO) begin
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].rd == q) begin
                    h = 1'b1;
                    d = sb[i].data;
                    break;
                end
            end
            if (!h && WriteEnable && out_e.rd == q) begin
                h = 1'b1;
                d = out_e.data;
            end
        end
    endfunction

    task automatic monitor_cycle();
        logic              h;
        logic [DATA_W-1:0] d;
        if (WriteEnable) begin
            if (sb.size() == 0) begin
                chk("spurious_write", WriteEnable, 0);
            end else begin
                out_e = sb.pop_front();
                chk("wr_reg", RegWrite, out_e.rd);
                chk("wr_data", DataWrite, out_e.data);
            end
        end
        chk("mem_ready", MemReady, sb.size() <= DEPTH - 1);
        chk("alu_ready", AluReady, sb.size() <= DEPTH - 2);
        if (!AluReady) saw_stall = 1'b1;
        chk("empty", Empty, (sb.size() == 0) && !WriteEnable);
        fwd(QueryReg1, h, d);
        chk("q1_hit", QueryHit1, h);
        chk("q1_data", QueryData1, d);
        fwd(QueryReg2, h, d);
        chk("q2_hit", QueryHit2, h);
        chk("q2_data", QueryData2, d);
    endtask

    // Monitor: samples 1 time unit after each rising edge
    initial begin
        forever begin
            @(posedge CLOCK);
            #1;
            if (mon_en && RESET) monitor_cycle();
        end
    end

    // Offer requests starting at a falling edge; hold each until accepted.
    // Returns at a falling edge with both valids dropped.
    task automatic send(input bit mv, input logic [REG_ADDR_W-1:0] mr, input logic [DATA_W-1:0] md,
                        input bit av, input logic [REG_ADDR_W-1:0] ar, input logic [DATA_W-1:0] ad);
        bit mp = mv;
        bit ap = av;
        int guard = 0;
        while (mp || ap) begin
            MemValid = mp; MemReg = mr; MemData = md;
            AluValid = ap; AluReg = ar; AluData = ad;
            #1;
            if (mp && MemReady) begin push_exp(mr, md); mp = 1'b0; end
            if (ap && AluReady) begin push_exp(ar, ad); ap = 1'b0; end
            @(negedge CLOCK);
            guard++;
            if (guard > 20) begin
                chk("send_timeout", guard, 0);
                break;
            end
        end
        MemValid = 1'b0;
        AluValid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit                    mp, ap;
        logic [REG_ADDR_W-1:0] mr, ar;
        logic [DATA_W-1:0]     md, ad;

        // Reset state
        QueryReg1 = 5'd3;
        #1 RESET = 1'b0;
        #2;
        chk("rst_we", WriteEnable, 0);
        chk("rst_regwrite", RegWrite, 0);
        chk("rst_datawrite", DataWrite, 0);
        chk("rst_empty", Empty, 1);
        chk("rst_hit1", QueryHit1, 0);
        chk("rst_memready", MemReady, 1);
        chk("rst_aluready", AluReady, 1);
        @(negedge CLOCK);
        @(negedge CLOCK);
        RESET  = 1'b1;
        mon_en = 1'b1;
        @(negedge CLOCK);

        // Single load r3=0x11: written the cycle after the following edge
        send(1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 32'h0);
        @(posedge CLOCK); #2;
        chk("lat_we", WriteEnable, 1);
        chk("lat_reg", RegWrite, 3);
        chk("lat_data", DataWrite, 32'h11);
        @(posedge CLOCK); #2;
        chk("lat_we_off", WriteEnable, 0);
        chk("lat_empty", Empty, 1);
        @(negedge CLOCK);

        // Same-edge Mem and Alu to r5: order A then B, youngest forwarded
        QueryReg1 = 5'd5;
        send(1'b1, 5'd5, 32'hA, 1'b1, 5'd5, 32'hB);
        #1;
        chk("r5_both_hit", QueryHit1, 1);
        chk("r5_both_data", QueryData1, 32'hB);
        @(posedge CLOCK); #2;
        chk("r5_first_reg", RegWrite, 5);
        chk("r5_first_data", DataWrite, 32'hA);
        chk("r5_fwd_mid", QueryData1, 32'hB);
        @(posedge CLOCK); #2;
        chk("r5_second_data", DataWrite, 32'hB);
        chk("r5_fwd_last", QueryData1, 32'hB);
        @(posedge CLOCK); #2;
        chk("r5_drained_hit", QueryHit1, 0);
        chk("r5_drained_data", QueryData1, 0);
        @(negedge CLOCK);

        // Back-to-back dual pushes: ALU stalls once the queue holds 3
        QueryReg1 = 5'd2;
        QueryReg2 = 5'd4;
        send(1'b1, 5'd1, 32'h101, 1'b1, 5'd2, 32'h102);
        send(1'b1, 5'd3, 32'h103, 1'b1, 5'd4, 32'h104);
        send(1'b1, 5'd5, 32'h105, 1'b1, 5'd6, 32'h106);
        repeat (6) @(posedge CLOCK);
        @(negedge CLOCK);
        chk("fill_alu_stall_seen", saw_stall, 1);
        chk("fill_drained", Empty, 1);

        // Write to r0: handshake completes, nothing queued or written
        QueryReg1 = 5'd0;
        send(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFF);
        #1;
        chk("r0_hit", QueryHit1, 0);
        chk("r0_empty", Empty, 1);
        @(posedge CLOCK); #2;
        chk("r0_no_write", WriteEnable, 0);
        @(negedge CLOCK);

        // Reset in the middle of traffic discards everything pending
        QueryReg1 = 5'd8;
        send(1'b1, 5'd7, 32'h7, 1'b1, 5'd8, 32'h8);
        send(1'b1, 5'd9, 32'h9, 1'b1, 5'd10, 32'h10);
        #3 RESET = 1'b0;
        #1;
        chk("mid_rst_we", WriteEnable, 0);
        chk("mid_rst_reg", RegWrite, 0);
        chk("mid_rst_data", DataWrite, 0);
        chk("mid_rst_empty", Empty, 1);
        chk("mid_rst_hit", QueryHit1, 0);
        sb.delete();
        @(negedge CLOCK);
        @(negedge CLOCK);
        RESET = 1'b1;
        #1;
        chk("post_rst_memready", MemReady, 1);
        chk("post_rst_aluready", AluReady, 1);
        chk("post_rst_empty", Empty, 1);
        repeat (3) @(posedge CLOCK);
        #2;
        chk("post_rst_no_write", WriteEnable, 0);
        @(negedge CLOCK);

        // Mixed traffic with small register range for forwarding collisions
        mp = 1'b0; ap = 1'b0;
        mr = '0; ar = '0; md = '0; ad = '0;
        for (int c = 0; c < 300; c++) begin
            if (!mp) begin
                mp = ($urandom_range(0, 2) != 0);
                mr = 5'($urandom_range(0, 7));
                md = $urandom;
            end
            if (!ap) begin
                ap = ($urandom_range(0, 2) != 0);
                ar = 5'($urandom_range(0, 7));
                ad = $urandom;
            end
            MemValid = mp; MemReg = mr; MemData = md;
            AluValid = ap; AluReg = ar; AluData = ad;
            QueryReg1 = 5'($urandom_range(0, 7));
            QueryReg2 = 5'($urandom_range(0, 7));
            #1;
            if (mp && MemReady) begin push_exp(mr, md); mp = 1'b0; end
            if (ap && AluReady) begin push_exp(ar, ad); ap = 1'b0; end
            @(negedge CLOCK);
        end
        MemValid = 1'b0;
        AluValid = 1'b0;
        repeat (8) @(negedge CLOCK);
        chk("final_none_lost", sb.size(), 0);
        chk("final_empty", Empty, 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
